ps2_keyboard_mmio: RTL and testbench

//   Keyboard end of the CPU's 0x003xxxxx read window: receives PS/2 device-to-host frames
//   and buffers the scancodes in a FIFO. The CPU reads them as memory-mapped data.

---
 rtl/ps2_defs.sv | 22 ++
 rtl/ps2_rx.sv | 100 ++++++++++
 rtl/ps2_keyboard_mmio.sv | 110 +++++++++++
 tb/tb_ps2_keyboard_mmio.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_defs.sv
// rtl/ps2_defs.sv - shared register offsets, frame constants and receiver states for the PS/2 keyboard port
package ps2_defs;

  // Register offsets as decoded from rdaddr[3:2]
  localparam logic [1:0] PS2_REG_DATA   = 2'd0;
  localparam logic [1:0] PS2_REG_STATUS = 2'd1;

  // Start + 8 data + parity + stop
  localparam int PS2_FRAME_LEN = 11;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_CHECK = 2'd2
  } rx_state_t;

  // Frame is stored with the start bit at [0] and the stop bit at [10]
  function automatic logic frame_ok(input logic [10:0] f);
    return (f[0] == 1'b0) && (f[10] == 1'b1) && ((^f[9:1]) == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host receiver: synchroniser, falling-edge detect, frame FSM, timeout
module ps2_rx
  import ps2_defs::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       rx_valid,
  output logic [7:0] rx_byte
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;
  logic [TW-1:0]          tcnt;
  logic                   timed_out;
  rx_state_t              state;
  logic [3:0]             bitcnt;
  logic [10:0]            frame;

  assign clk_s     = clk_sync[SYNC_STAGES-1];
  assign data_s    = data_sync[SYNC_STAGES-1];
  assign fall      = clk_prev & ~clk_s;
  assign timed_out = (tcnt == TW'(TIMEOUT));

  // Bring both PS/2 lines into the clock domain; idle level of the bus is 1
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_s;
    end
  end

  // Cycles since the last ps2_clk falling edge, saturating at TIMEOUT
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
    end else if (fall) begin
      tcnt <= '0;
    end else if (!timed_out) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // Frame FSM: bits shift in from the top so the start bit lands at frame[0]
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RX_IDLE;
      bitcnt   <= 4'd0;
      frame    <= 11'd0;
      rx_valid <= 1'b0;
      rx_byte  <= 8'd0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (fall && !data_s) begin
            frame  <= {data_s, 10'd0};
            bitcnt <= 4'd1;
            state  <= RX_SHIFT;
          end
        end
        RX_SHIFT: begin
          if (fall) begin
            frame  <= {data_s, frame[10:1]};
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt == 4'(PS2_FRAME_LEN - 1)) begin
              state <= RX_CHECK;
            end
          end else if (timed_out) begin
            state <= RX_IDLE;
          end
        end
        RX_CHECK: begin
          if (frame_ok(frame)) begin
            rx_valid <= 1'b1;
            rx_byte  <= frame[8:1];
          end
          state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keyboard_mmio.sv
// rtl/ps2_keyboard_mmio.sv - PS/2 keyboard scancode FIFO exposed as a CPU read-only register window
module ps2_keyboard_mmio
  import ps2_defs::*;
#(
  parameter int FIFO_AW     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic [31:0] rdaddr,
  input  logic        rden,
  output logic [31:0] dataout,
  output logic        overflow
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic             rx_valid;
  logic [7:0]       rx_byte;
  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [1:0]       sel;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             ovf_set;
  logic             ovf_clr;
  logic             unused_addr;

  assign unused_addr = ^{rdaddr[31:4], rdaddr[1:0]};

  ps2_rx #(
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT    (TIMEOUT)
  ) u_rx (
    .clock   (clock),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_valid(rx_valid),
    .rx_byte (rx_byte)
  );

  assign sel     = rdaddr[3:2];
  assign empty   = (count == '0);
  assign full    = (count == (FIFO_AW+1)'(DEPTH));
  assign pop     = rden && (sel == PS2_REG_DATA) && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is fine then
  assign push    = rx_valid && (!full || pop);
  assign ovf_set = rx_valid && full && !pop;
  assign ovf_clr = rden && (sel == PS2_REG_STATUS);

  // Scancode storage; contents are only observable through the head pointer when non-empty
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= rx_byte;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a STATUS read keeps it set
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // Read mux; held at zero while reset is asserted
  always_comb begin
    dataout = 32'd0;
    if (!reset) begin
      case (sel)
        PS2_REG_DATA:   dataout = {23'd0, ~empty, (empty ? 8'd0 : mem[rd_ptr])};
        PS2_REG_STATUS: dataout = {16'd0, 8'(count), 6'd0, overflow, empty};
        default:        dataout = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_mmio.sv
// tb/tb_ps2_keyboard_mmio.sv - randomized self-checking bench for ps2_keyboard_mmio against a queue model
`timescale 1ns/1ps
module tb_ps2_keyboard_mmio;

  localparam int TOUT = 300;
  localparam int HALF = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] rdaddr = 32'h0030_0000;
  logic        rden = 1'b0;
  logic [31:0] dataout;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  logic [7:0] q[$];
  logic       m_ovf = 1'b0;

  ps2_keyboard_mmio #(
    .FIFO_AW    (3),
    .SYNC_STAGES(2),
    .TIMEOUT    (TOUT)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rdaddr  (rdaddr),
    .rden    (rden),
    .dataout (dataout),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_value(input int a);
    if (a == 0) return (q.size() == 0) ? 32'd0 : {23'd0, 1'b1, q[0]};
    if (a == 1) return {16'd0, 8'(q.size()), 6'd0, m_ovf, (q.size() == 0)};
    return 32'd0;
  endfunction

  function automatic void model_read(input int a);
    if (a == 0 && q.size() != 0) void'(q.pop_front());
    if (a == 1) m_ovf = 1'b0;
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (q.size() < 8) q.push_back(b);
    else m_ovf = 1'b1;
  endfunction

  // Strobed CPU read; called with inputs changing on the falling clock edge
  task automatic cpu_read(input int a, input string tag);
    logic [31:0] exp;
    exp = model_value(a);
    rdaddr = 32'h0030_0000 | (32'(a) << 2);
    rden = 1'b1;
    #1;
    check(tag, dataout, exp);
    model_read(a);
    @(negedge clock);
    rden = 1'b0;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~(^b) ^ bad_par;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  // Drive the first n bits of a frame; with pop_mid the last falling edge lines a DATA pop up with the push
  task automatic drive_bits(input logic [10:0] f, input int n, input bit pop_mid);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      ps2_data = f[i];
      repeat (HALF) @(negedge clock);
      ps2_clk = 1'b0;
      if (pop_mid && i == n - 1) begin
        repeat (4) @(negedge clock);
        cpu_read(0, "pop_with_push");
        model_push(f[8:1]);
        repeat (HALF - 5) @(negedge clock);
      end else begin
        repeat (HALF) @(negedge clock);
      end
      ps2_clk = 1'b1;
    end
    @(negedge clock);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clock);
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    drive_bits(make_frame(b, bad_par, bad_stop), 11, 1'b0);
    if (!bad_par && !bad_stop) model_push(b);
  endtask

  initial begin
    logic [7:0] b;
    int ra;
    // Reset state: every register reads zero while reset is asserted
    repeat (3) @(negedge clock);
    for (int a = 0; a < 4; a++) begin
      rdaddr = 32'h0030_0000 | (32'(a) << 2);
      #1;
      check("reset_dataout", dataout, 32'd0);
    end
    check("reset_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    cpu_read(1, "status_after_reset");
    cpu_read(2, "reg2_zero");
    cpu_read(3, "reg3_zero");

    // Single scancode, then a read of the empty FIFO
    send(8'h1C, 0, 0);
    check("model_0x11c", model_value(0), 32'h11C);
    cpu_read(0, "data_1c");
    cpu_read(0, "data_empty");

    // Two scancodes in order
    send(8'hF0, 0, 0);
    send(8'h1C, 0, 0);
    cpu_read(1, "status_cnt2");
    cpu_read(0, "data_f0");
    cpu_read(1, "status_cnt1");
    cpu_read(0, "data_1c_b");
    cpu_read(1, "status_cnt0");

    // Bad parity and bad stop are discarded
    send(8'h1C, 1, 0);
    send(8'h1C, 0, 1);
    cpu_read(1, "status_bad_frames");

    // Overflow after nine frames, then clear on STATUS read
    for (int i = 0; i < 9; i++) send(8'($urandom_range(0, 255)), 0, 0);
    cpu_read(1, "status_overflow");
    cpu_read(1, "status_ovf_cleared");

    // Push and pop coincide while full
    drive_bits(make_frame(8'h5A, 0, 0), 11, 1'b1);
    cpu_read(1, "status_full_no_ovf");
    for (int i = 0; i < 8; i++) cpu_read(0, "drain_full");
    cpu_read(1, "status_drained");

    // Randomized frames and reads
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      send(b, ($urandom_range(0, 5) == 0), 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        ra = int'($urandom_range(0, 3));
        cpu_read(ra, "random_read");
      end
    end
    while (q.size() != 0) cpu_read(0, "random_drain");
    cpu_read(1, "status_random_end");

    // Partial frame abandoned by timeout
    drive_bits(make_frame(8'h77, 0, 0), 5, 1'b0);
    repeat (TOUT + 100) @(negedge clock);
    send(8'h29, 0, 0);
    check("model_0x129", model_value(0), 32'h129);
    cpu_read(0, "data_after_timeout");
    cpu_read(1, "status_after_timeout");

    // Reset mid-frame discards everything
    drive_bits(make_frame(8'h77, 0, 0), 5, 1'b0);
    reset = 1'b1;
    #1;
    check("midreset_data", dataout, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    @(negedge clock);
    cpu_read(1, "status_after_midreset");
    send(8'h29, 0, 0);
    cpu_read(0, "data_after_midreset");
    cpu_read(1, "status_final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the run cannot hang
  initial begin
    #5ms;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "time limit");
  end

endmodule
